// File: rtl/obi_mem_responder.sv
// obi_mem_responder
//
// OBI responder backed by a word-organised memory. Requests are granted
// after GNT_WAIT cycles of a held request, executed in the grant cycle and
// answered exactly RVALID_LAT cycles later, strictly in order. At most
// MAX_OUTSTANDING transactions may be granted but not yet answered.
//
// Handshake: the address phase completes in a cycle where obi_req_i and
// obi_gnt_o are both high. The initiator is always ready for responses, so
// obi_rvalid_o is a single-cycle pulse per transaction with no back-pressure.
//
// Build option: define OBI_MEM_RESPONDER_ERR_EN to answer addresses at or
// above MEM_WORDS*4 with err=1 and rdata=0, leaving memory untouched.
// Without it, upper address bits are ignored (the address wraps) and
// obi_err_o is always 0.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   obi_req_i       request valid
//   obi_gnt_o       grant
//   obi_addr_i      byte address, bits [1:0] ignored
//   obi_we_i        1 = write, 0 = read
//   obi_be_i        byte enables for writes (byte b = bits 8b+7:8b)
//   obi_wdata_i     write data
//   obi_atop_i      atomic opcode, accepted and ignored
//   obi_rvalid_o    response valid
//   obi_rdata_o     read data, 0 for writes and errors
//   obi_err_o       response error, qualified by obi_rvalid_o
//   dbg_state_o     current grant FSM state (IDLE=0, WAIT=1, GNT=2)
module obi_mem_responder #(
  parameter int WIDTH           = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int GNT_WAIT        = 0,
  parameter int RVALID_LAT      = 1,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obi_req_i,
  output logic             obi_gnt_o,
  input  logic [WIDTH-1:0] obi_addr_i,
  input  logic             obi_we_i,
  input  logic [3:0]       obi_be_i,
  input  logic [WIDTH-1:0] obi_wdata_i,
  input  logic [5:0]       obi_atop_i,
  output logic             obi_rvalid_o,
  output logic [WIDTH-1:0] obi_rdata_o,
  output logic             obi_err_o,
  output logic [1:0]       dbg_state_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0] GNT_WAIT_C = 4'(GNT_WAIT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_GNT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [OW-1:0] outstanding_q;
  logic          gnt_ok;
  logic          can_accept;
  logic          hs;

  // A response retiring this cycle frees its slot immediately.
  assign can_accept = (int'(outstanding_q) - int'(obi_rvalid_o)) < MAX_OUTSTANDING;

  // Grant FSM: wait_cnt counts cycles the request has been held. The
  // transition into GNT is taken when the incremented count reaches
  // GNT_WAIT, so the grant lands exactly GNT_WAIT cycles after req rose.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt_ok     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (obi_req_i) begin
          if (GNT_WAIT == 0) begin
            // Behave as GNT this cycle; park in GNT for back-to-back traffic.
            gnt_ok  = 1'b1;
            state_d = ST_GNT;
          end else if (GNT_WAIT == 1) begin
            state_d = ST_GNT;
          end else begin
            wait_cnt_d = 4'd1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!obi_req_i) begin
          wait_cnt_d = 4'd0;
          state_d    = ST_IDLE;
        end else if (wait_cnt_q + 4'd1 == GNT_WAIT_C) begin
          wait_cnt_d = 4'd0;
          state_d    = ST_GNT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_GNT: begin
        if (!obi_req_i) begin
          state_d = ST_IDLE;
        end else begin
          gnt_ok = 1'b1;
          // A blocked request holds here; a completed one restarts the wait
          // unless grants are immediate.
          if (can_accept && GNT_WAIT != 0) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Gated by rst_n so no grant is visible while reset is asserted.
  assign obi_gnt_o   = rst_n && obi_req_i && gnt_ok && can_accept;
  assign hs          = obi_gnt_o;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
    end else begin
      case ({hs, obi_rvalid_o})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Memory and execution
  logic [WIDTH-1:0] mem [MEM_WORDS];
  logic [AW-1:0]    widx;
  logic             oob;
  logic [WIDTH-1:0] rd_word;

  assign widx = obi_addr_i[AW+1:2];

`ifdef OBI_MEM_RESPONDER_ERR_EN
  assign oob = |(obi_addr_i >> (AW + 2));
`else
  assign oob = 1'b0;
`endif

  // Read sees the word as it stood before the edge; only one transaction
  // executes per cycle, so there is no read/write hazard.
  assign rd_word = (obi_we_i || oob) ? '0 : mem[widx];

  // Byte lanes follow the 4-bit byte-enable port (WIDTH is 32 in practice).
  always_ff @(posedge clk) begin
    if (hs && obi_we_i && !oob) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_be_i[b]) mem[widx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
      end
    end
  end

  // Response pipeline: stage 0 is captured at the grant edge and reaches
  // the outputs RVALID_LAT cycles later. Idle stages carry zeros.
  logic             pipe_valid [RVALID_LAT];
  logic [WIDTH-1:0] pipe_rdata [RVALID_LAT];
  logic             pipe_err   [RVALID_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RVALID_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rdata[i] <= '0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= hs;
      pipe_rdata[0] <= hs ? rd_word : '0;
      pipe_err[0]   <= hs & oob;
      for (int i = 1; i < RVALID_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign obi_rvalid_o = pipe_valid[RVALID_LAT-1];
  assign obi_rdata_o  = pipe_rdata[RVALID_LAT-1];
  assign obi_err_o    = pipe_err[RVALID_LAT-1];

  logic unused_inputs;
  assign unused_inputs = ^{obi_atop_i, obi_addr_i};

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder. Four instances with different grant-wait,
// latency and outstanding settings share one clock and reset. A reference
// model (memory array plus a queue of expected responses with due cycles)
// predicts gnt, rvalid, rdata and err for every instance on every cycle.
module tb_obi_mem_responder;

  localparam int NI = 4;
  localparam int MEM_WORDS_TB = 1024;
  localparam int GW_P  [NI] = '{0, 0, 0, 3};
  localparam int LAT_P [NI] = '{1, 4, 2, 1};
  localparam int MAX_P [NI] = '{1, 2, 2, 1};

`ifdef OBI_MEM_RESPONDER_ERR_EN
  localparam bit          ERR_MODEL = 1'b1;
  localparam logic        OOB_ERR   = 1'b1;
  localparam logic [31:0] W0_AFTER  = 32'h0123_4567;
  localparam logic [31:0] OOB_RD    = 32'h0000_0000;
`else
  localparam bit          ERR_MODEL = 1'b0;
  localparam logic        OOB_ERR   = 1'b0;
  localparam logic [31:0] W0_AFTER  = 32'hDEAD_BEEF;
  localparam logic [31:0] OOB_RD    = 32'hAA22_CC44;
`endif

  // Clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        req    [NI];
  logic        gnt    [NI];
  logic [31:0] addr   [NI];
  logic        we     [NI];
  logic [3:0]  be     [NI];
  logic [31:0] wdata  [NI];
  logic [5:0]  atop   [NI];
  logic        rvalid [NI];
  logic [31:0] rdata  [NI];
  logic        err    [NI];
  logic [1:0]  dbg_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    obi_mem_responder #(
      .WIDTH(32), .MEM_WORDS(MEM_WORDS_TB), .GNT_WAIT(GW_P[g]),
      .RVALID_LAT(LAT_P[g]), .MAX_OUTSTANDING(MAX_P[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .obi_req_i(req[g]), .obi_gnt_o(gnt[g]), .obi_addr_i(addr[g]),
      .obi_we_i(we[g]), .obi_be_i(be[g]), .obi_wdata_i(wdata[g]),
      .obi_atop_i(atop[g]), .obi_rvalid_o(rvalid[g]), .obi_rdata_o(rdata[g]),
      .obi_err_o(err[g]), .dbg_state_o(dbg_state[g])
    );
  end

  // Checking
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard / reference model
  typedef struct packed {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [NI][$];
  logic [31:0] mmem  [NI][MEM_WORDS_TB];
  int          held  [NI];

  always @(negedge clk) begin
    exp_t        e;
    logic        due_now;
    logic        exp_g;
    int unsigned wi;
    logic        oob_m;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        exp_q[k].delete();
        held[k] = 0;
        chk($sformatf("k%0d_rst_gnt", k), gnt[k], 0);
        chk($sformatf("k%0d_rst_rvalid", k), rvalid[k], 0);
        chk($sformatf("k%0d_rst_rdata", k), rdata[k], 0);
        chk($sformatf("k%0d_rst_err", k), err[k], 0);
      end else begin
        due_now = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
        if (due_now) begin
          e = exp_q[k].pop_front();
          chk($sformatf("k%0d_rvalid", k), rvalid[k], 1);
          chk($sformatf("k%0d_rdata", k), rdata[k], e.rdata);
          chk($sformatf("k%0d_err", k), err[k], e.err);
        end else begin
          chk($sformatf("k%0d_rvalid_idle", k), rvalid[k], 0);
        end
        // Remaining queue entries are the slots still occupied this cycle.
        exp_g = req[k] && (held[k] >= GW_P[k]) && (exp_q[k].size() < MAX_P[k]);
        chk($sformatf("k%0d_gnt", k), gnt[k], exp_g);
        if (exp_g) begin
          wi    = (addr[k] >> 2) % MEM_WORDS_TB;
          oob_m = addr[k] >= 32'(MEM_WORDS_TB * 4);
          e.due = cyc + LAT_P[k];
          e.err = 1'b0;
          e.rdata = 32'h0;
          if (ERR_MODEL && oob_m) begin
            e.err = 1'b1;
          end else if (we[k]) begin
            for (int b = 0; b < 4; b++)
              if (be[k][b]) mmem[k][wi][8*b +: 8] = wdata[k][8*b +: 8];
          end else begin
            e.rdata = mmem[k][wi];
          end
          exp_q[k].push_back(e);
          held[k] = 0;
        end else if (req[k]) begin
          held[k] = held[k] + 1;
        end else begin
          held[k] = 0;
        end
      end
    end
  end

  // Driver: one complete transaction, returns response and latency
  task automatic do_txn(input int k, input logic we_v, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = we_v; addr[k] = a; be[k] = b; wdata[k] = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt[k]) break;
      n++;
      if (n > 50) begin
        chk($sformatf("k%0d_gnt_timeout", k), 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
    lat = 1;
    forever begin
      @(negedge clk);
      if (rvalid[k]) break;
      lat++;
      if (lat > 20) begin
        chk($sformatf("k%0d_rvalid_timeout", k), 0, 1);
        break;
      end
    end
    rd = rdata[k];
    er = err[k];
  endtask

  // Table of directed vectors applied to instance 0 (GNT_WAIT=0, RVALID_LAT=1)
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [5:0]  gh, rh;
    int          n_g, n_r, rv_cnt;

    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0;
      wdata[k] = '0; atop[k] = '0;
    end

    vecs[0] = '{1'b1, 32'h10,   4'b1111, 32'hAABB_CCDD, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h10,   4'b0101, 32'h1122_3344, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'h10,   4'b0000, 32'h0,         32'hAA22_CC44, 1'b0};
    vecs[3] = '{1'b1, 32'h0,    4'b1111, 32'h0123_4567, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h1000, 4'b1111, 32'hDEAD_BEEF, 32'h0, OOB_ERR};
    vecs[5] = '{1'b0, 32'h0,    4'b0000, 32'h0,         W0_AFTER, 1'b0};
    vecs[6] = '{1'b0, 32'h1010, 4'b0000, 32'h0,         OOB_RD, OOB_ERR};
    vecs[7] = '{1'b1, 32'h12,   4'b0010, 32'h0000_5500, 32'h0, 1'b0};
    vecs[8] = '{1'b0, 32'h10,   4'b0000, 32'h0,         32'hAA22_5544, 1'b0};
    vecs[9] = '{1'b1, 32'hFFC,  4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Prefill words 0..15 of every instance so all later reads are defined.
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 16; w++)
        do_txn(k, 1'b1, 32'(w << 2), 4'hF, $urandom, rd, er, lat);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      chk($sformatf("vec%0d_lat", i), lat, 1);
    end
    do_txn(0, 1'b0, 32'hFFC, 4'h0, 32'h0, rd, er, lat);
    chk("top_word_rdata", rd, 32'hCAFE_F00D);

    // Wait states: instance 3, GNT_WAIT=3, req held from cycle 0
    @(posedge clk); #1;
    req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h20; be[3] = 4'hF; wdata[3] = $urandom;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      gh[c] = gnt[3];
      rh[c] = rvalid[3];
      @(posedge clk); #1;
      if (c == 5) req[3] = 1'b0;
    end
    chk("wait_gnt_cycles", gh, 6'b001000);
    chk("wait_rvalid_cycles", rh, 6'b010000);
    repeat (4) @(posedge clk);

    // Outstanding limit: instance 1, RVALID_LAT=4, MAX_OUTSTANDING=2
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      gh[c] = gnt[1];
      rh[c] = rvalid[1];
      @(posedge clk); #1;
      if (gh[c]) addr[1] = addr[1] + 32'd4;
      if (c == 5) req[1] = 1'b0;
    end
    chk("outst_gnt_cycles", gh, 6'b110011);
    chk("outst_rvalid_cycles", rh, 6'b110000);
    repeat (8) @(posedge clk);

    // Back-to-back reads: instance 2, RVALID_LAT=MAX_OUTSTANDING=2
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'h0; addr[2] = 32'h0;
    n_g = 0;
    n_r = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      gh[c] = gnt[2];
      rh[c] = rvalid[2];
      if (rvalid[2]) begin
        chk($sformatf("b2b_rdata%0d", n_r), rdata[2], mmem[2][n_r % 16]);
        n_r++;
      end
      @(posedge clk); #1;
      if (gh[c]) begin
        n_g++;
        addr[2] = addr[2] + 32'd4;
        if (n_g == 3) req[2] = 1'b0;
      end
    end
    chk("b2b_gnt_cycles", gh, 6'b000111);
    chk("b2b_rvalid_cycles", rh, 6'b011100);
    repeat (4) @(posedge clk);

    // Reset mid-burst: two reads pending on instance 1
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h0;
    @(negedge clk);
    chk("rst_burst_gnt0", gnt[1], 1);
    @(posedge clk); #1;
    addr[1] = 32'h4;
    @(negedge clk);
    chk("rst_burst_gnt1", gnt[1], 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req[1] = 1'b0;
    req[0] = 1'b1;
    @(negedge clk);
    chk("rst_gnt_gated", gnt[0], 0);
    chk("rst_rvalid_low", rvalid[1], 0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid[1]) rv_cnt++;
    end
    chk("rst_no_stale_rvalid", rv_cnt, 0);
    do_txn(1, 1'b0, 32'h8, 4'h0, 32'h0, rd, er, lat);
    chk("post_rst_rdata", rd, mmem[1][2]);
    chk("post_rst_lat", lat, 4);

    // Randomized traffic on all instances, checked by the model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        req[k]   = ($urandom_range(0, 9) < 7);
        we[k]    = 1'($urandom_range(0, 1));
        addr[k]  = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) addr[k] = addr[k] | 32'h1000;
        be[k]    = 4'($urandom_range(0, 15));
        wdata[k] = $urandom;
        atop[k]  = 6'($urandom_range(0, 63));
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) req[k] = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++)
      chk($sformatf("k%0d_drained", k), exp_q[k].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
